// File: rtl/sn76489_psg.sv
// rtl/sn76489_psg.sv - SN76489A-compatible three-tone, one-noise sound generator
module sn76489_psg #(
    parameter int c_prescale  = 16,  // ce pulses per generator tick
    parameter int c_lfsr_bits = 15   // noise shift-register length
) (
    input  logic       clk,        // cpuClock
    input  logic       reset,      // synchronous, active-high
    input  logic       ce,         // generator clock enable, same as the Z80
    input  logic       wr,         // one-clk write strobe from the sound port decode
    input  logic [7:0] din,        // byte written by the CPU
    output logic [9:0] audio_out   // unsigned mix of all four channels, 0..1020
);

    localparam int                     c_pw        = (c_prescale > 1) ? $clog2(c_prescale) : 1;
    localparam logic [c_pw-1:0]        c_pre_last  = c_pw'(c_prescale - 1);
    localparam logic [c_lfsr_bits-1:0] c_lfsr_seed = {1'b1, {(c_lfsr_bits-1){1'b0}}};

    logic [c_pw-1:0]        prescaler;
    logic                   tick;
    logic [2:0][9:0]        period;
    logic [2:0][10:0]       tone_cnt;
    logic [2:0]             tone_out;
    logic [3:0][3:0]        atten;
    logic [2:0]             noise_ctl;
    logic [6:0]             noise_cnt;
    logic                   nclk;
    logic [c_lfsr_bits-1:0] lfsr;
    logic [1:0]             latch_ch;
    logic                   latch_vol;

    logic [6:0]             noise_half;
    logic                   nclk_rise;
    logic                   noise_wr;
    logic                   lfsr_fb;
    logic [9:0]             mix;

    // 2 dB attenuation steps; 15 is silence
    function automatic logic [7:0] amp_of(input logic [3:0] a);
        case (a)
            4'd0:    amp_of = 8'd255;
            4'd1:    amp_of = 8'd203;
            4'd2:    amp_of = 8'd161;
            4'd3:    amp_of = 8'd128;
            4'd4:    amp_of = 8'd102;
            4'd5:    amp_of = 8'd81;
            4'd6:    amp_of = 8'd64;
            4'd7:    amp_of = 8'd51;
            4'd8:    amp_of = 8'd40;
            4'd9:    amp_of = 8'd32;
            4'd10:   amp_of = 8'd26;
            4'd11:   amp_of = 8'd20;
            4'd12:   amp_of = 8'd16;
            4'd13:   amp_of = 8'd13;
            4'd14:   amp_of = 8'd10;
            default: amp_of = 8'd0;
        endcase
    endfunction

    assign tick    = ce && (prescaler == c_pre_last);
    assign lfsr_fb = noise_ctl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];

    // Any write that lands on the noise-control register reloads the LFSR
    assign noise_wr = wr && ((din[7] && !din[4] && (din[6:5] == 2'd3)) ||
                             (!din[7] && !latch_vol && (latch_ch == 2'd3)));

    always_comb begin
        noise_half = 7'd64;
        nclk_rise  = 1'b0;
        case (noise_ctl[1:0])
            2'd0:    noise_half = 7'd16;
            2'd1:    noise_half = 7'd32;
            default: noise_half = 7'd64;   // source 3 ignores the divider
        endcase
        // Rising edge of the selected noise clock, taken from the toggle about to happen
        if (noise_ctl[1:0] == 2'd3)
            nclk_rise = tick && (tone_cnt[2] <= 11'd1) && !tone_out[2];
        else
            nclk_rise = tick && (noise_cnt <= 7'd1) && !nclk;
    end

    always_comb begin
        mix = 10'd0;
        for (int i = 0; i < 3; i++)
            if (tone_out[i])
                mix = mix + {2'b00, amp_of(atten[i])};
        if (lfsr[0])
            mix = mix + {2'b00, amp_of(atten[3])};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            period    <= '0;
            tone_cnt  <= '0;
            tone_out  <= '0;
            atten     <= {4{4'hF}};
            noise_ctl <= '0;
            noise_cnt <= '0;
            nclk      <= 1'b0;
            lfsr      <= c_lfsr_seed;
            latch_ch  <= 2'd0;
            latch_vol <= 1'b0;
            audio_out <= '0;
        end else begin
            if (ce)
                prescaler <= tick ? '0 : prescaler + 1'b1;

            // Counters reload from the registers as they stand before this clk's write
            if (tick) begin
                for (int i = 0; i < 3; i++) begin
                    if (tone_cnt[i] <= 11'd1) begin
                        tone_cnt[i] <= (period[i] == 10'd0) ? 11'd1024 : {1'b0, period[i]};
                        tone_out[i] <= ~tone_out[i];
                    end else begin
                        tone_cnt[i] <= tone_cnt[i] - 11'd1;
                    end
                end
                if (noise_cnt <= 7'd1) begin
                    noise_cnt <= noise_half;
                    nclk      <= ~nclk;
                end else begin
                    noise_cnt <= noise_cnt - 7'd1;
                end
            end

            if (noise_wr)
                lfsr <= c_lfsr_seed;
            else if (nclk_rise)
                lfsr <= {lfsr_fb, lfsr[c_lfsr_bits-1:1]};

            if (wr) begin
                if (din[7]) begin
                    latch_ch  <= din[6:5];
                    latch_vol <= din[4];
                    if (din[4])
                        atten[din[6:5]] <= din[3:0];
                    else if (din[6:5] == 2'd3)
                        noise_ctl <= din[2:0];
                    else
                        for (int i = 0; i < 3; i++)
                            if (din[6:5] == 2'(i))
                                period[i][3:0] <= din[3:0];
                end else begin
                    if (latch_vol)
                        atten[latch_ch] <= din[3:0];
                    else if (latch_ch == 2'd3)
                        noise_ctl <= din[2:0];
                    else
                        for (int i = 0; i < 3; i++)
                            if (latch_ch == 2'(i))
                                period[i][9:4] <= din[5:0];
                end
            end

            audio_out <= mix;
        end
    end

endmodule

// File: tb/tb_sn76489_psg.sv
// tb/tb_sn76489_psg.sv - randomized and directed checks of sn76489_psg against a tick-timestamp model
module tb_sn76489_psg;

    logic       clk;
    logic       reset;
    logic       ce;
    logic       wr;
    logic [7:0] din;
    logic [9:0] audio_out;

    sn76489_psg dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .wr        (wr),
        .din       (din),
        .audio_out (audio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tones and noise divider as absolute tick timestamps of their next toggle
    int amp_tab [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
    int m_period [3];
    int m_next_tone [3];
    int m_tone [3];
    int m_atten [4];
    int m_ctl, m_lfsr, m_next_nd, m_nd;
    int m_latch_ch, m_latch_vol, m_ce_count, m_tick, m_audio;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_period[i]    = 0;
            m_next_tone[i] = 1;
            m_tone[i]      = 0;
        end
        for (int i = 0; i < 4; i++) m_atten[i] = 15;
        m_ctl = 0; m_lfsr = 'h4000; m_next_nd = 1; m_nd = 0;
        m_latch_ch = 0; m_latch_vol = 0; m_ce_count = 0; m_tick = 0; m_audio = 0;
    endtask

    function automatic int model_mix();
        int s = 0;
        for (int i = 0; i < 3; i++) if (m_tone[i] != 0) s += amp_tab[m_atten[i]];
        if ((m_lfsr & 1) != 0) s += amp_tab[m_atten[3]];
        return s;
    endfunction

    task automatic model_step(input bit rst, input bit c, input bit w, input int d);
        int  nxt_audio;
        int  sel;
        int  fb;
        bit  rise;
        if (rst) begin
            model_reset();
            return;
        end
        nxt_audio = model_mix();
        sel  = m_ctl & 3;
        rise = 1'b0;
        if (c) begin
            m_ce_count++;
            if (m_ce_count % 16 == 0) begin
                m_tick++;
                for (int i = 0; i < 3; i++) begin
                    if (m_tick == m_next_tone[i]) begin
                        m_tone[i]      = 1 - m_tone[i];
                        m_next_tone[i] = m_tick + ((m_period[i] == 0) ? 1024 : m_period[i]);
                        if (i == 2 && m_tone[2] == 1 && sel == 3) rise = 1'b1;
                    end
                end
                if (m_tick == m_next_nd) begin
                    m_nd      = 1 - m_nd;
                    m_next_nd = m_tick + ((sel == 3) ? 64 : (16 << sel));
                    if (m_nd == 1 && sel != 3) rise = 1'b1;
                end
                if (rise) begin
                    fb     = ((m_ctl & 4) != 0) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
                    m_lfsr = (m_lfsr >> 1) | (fb << 14);
                end
            end
        end
        if (w) begin
            if ((d & 128) != 0) begin
                m_latch_ch  = (d >> 5) & 3;
                m_latch_vol = (d >> 4) & 1;
                if (m_latch_vol != 0)  m_atten[m_latch_ch] = d & 15;
                else if (m_latch_ch < 3) m_period[m_latch_ch] = (m_period[m_latch_ch] & 'h3F0) | (d & 15);
                else begin m_ctl = d & 7; m_lfsr = 'h4000; end
            end else begin
                if (m_latch_vol != 0)  m_atten[m_latch_ch] = d & 15;
                else if (m_latch_ch < 3) m_period[m_latch_ch] = (m_period[m_latch_ch] & 15) | ((d & 63) << 4);
                else begin m_ctl = d & 7; m_lfsr = 'h4000; end
            end
        end
        m_audio = nxt_audio;
    endtask

    always @(posedge clk) model_step(reset, ce, wr, int'(din));

    always @(negedge clk) if (chk_en) check("audio_model", int'(audio_out), m_audio);

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr  = 1'b1;
        din = b;
        @(negedge clk);
        wr  = 1'b0;
    endtask

    task automatic wait_change(input int bound, output int n);
        int v;
        v = int'(audio_out);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(audio_out) == v && n <= bound);
    endtask

    task automatic wait_level(input int target, input int bound, output int n);
        n = 0;
        while (int'(audio_out) != target && n <= bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Random bytes; noise clock source 3 is kept out of the random phase
    function automatic logic [7:0] gen_byte();
        logic [7:0] b;
        if ($urandom_range(0, 1) == 1) b = 8'($urandom) | 8'h80;
        else if ($urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 7));
        else b = 8'($urandom_range(0, 63));
        if ((b[7] && !b[4] && b[6:5] == 2'd3) || (!b[7] && m_latch_vol == 0 && m_latch_ch == 3))
            if (b[1:0] == 2'b11) b[1:0] = 2'b10;
        return b;
    endfunction

    initial begin
        int n;
        int mx;
        int lvl;
        reset = 1'b1; ce = 1'b1; wr = 1'b0; din = 8'h00;
        model_reset();

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_audio", int'(audio_out), 0);
        reset = 1'b0;
        mx = 0;
        repeat (10000) begin
            @(negedge clk);
            if (int'(audio_out) > mx) mx = int'(audio_out);
        end
        check("reset_quiet", mx, 0);

        do_reset();
        wr_byte(8'h81); wr_byte(8'h01); wr_byte(8'h90);
        wait_change(100, n);
        check("tone_first_lvl", int'(audio_out), 255);
        lvl = 0;
        for (int k = 0; k < 4; k++) begin
            wait_change(400, n);
            check("tone_half_len", n, 272);
            check("tone_lvl", int'(audio_out), lvl);
            lvl = 255 - lvl;
        end

        wr_byte(8'h9F); wr_byte(8'h05);
        wait_level(81, 700, n);
        check("vol_81", int'(audio_out), 81);
        wait_change(400, n);
        wr_byte(8'h80); wr_byte(8'h00);
        wait_change(400, n);
        check("p0_lvl", int'(audio_out), 81);
        wait_change(17000, n);
        check("p0_half_len", n, 16384);

        do_reset();
        wr_byte(8'hE4); wr_byte(8'hF0);
        wait_change(7300, n);
        check("white_lvl", int'(audio_out), 255);
        check("white_first_one", (n >= 6657 && n <= 7168) ? 1 : 0, 1);
        wait_change(600, n);
        check("white_one_len", n, 512);

        do_reset();
        wr_byte(8'hE3); wr_byte(8'hC4); wr_byte(8'h80); wr_byte(8'hF0);
        wait_level(255, 2500, n);
        check("per_first", int'(audio_out), 255);
        wait_change(300, n);
        check("per_one_len", n, 128);
        wait_change(2000, n);
        check("per_gap", n, 1792);
        check("per_lvl", int'(audio_out), 255);

        do_reset();
        wr_byte(8'h90); wr_byte(8'hB0); wr_byte(8'hD0); wr_byte(8'hF0);
        wait_level(1020, 9000, n);
        check("mix_full", int'(audio_out), 1020);
        reset = 1'b1;
        @(negedge clk);
        check("mix_reset", int'(audio_out), 0);
        @(negedge clk);
        reset = 1'b0;

        repeat (20000) begin
            @(negedge clk);
            ce    = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 2999) == 0);
            wr    = ($urandom_range(0, 47) == 0);
            din   = gen_byte();
        end
        reset = 1'b0; wr = 1'b0; ce = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
